// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : issue_scoreboard (with package ariane_pkg)
// Brief   : In-order issue/commit scoreboard; ids are circular-buffer slots.
//           Operand forwarding is built only when SB_FORWARD_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================

package ariane_pkg;
  // Stored id field is sized for the deepest supported buffer (256 entries).
  localparam int unsigned TRANS_ID_MAX_W = 8;

  typedef enum logic [2:0] {NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR} fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0]               pc;
    logic [TRANS_ID_MAX_W-1:0] trans_id;
    fu_t                       fu;
    logic [4:0]                rs1;
    logic [4:0]                rs2;
    logic [4:0]                rd;
    logic [63:0]               result;
    logic                      valid;
    exception_t                ex;
  } scoreboard_entry;
endpackage

module issue_scoreboard
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES  = 8,
  parameter int unsigned NR_WB_PORTS = 2,
  localparam int unsigned TRANS_ID_W = $clog2(NR_ENTRIES)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    flush_i,
  output logic                                    full_o,
  input  scoreboard_entry                         decoded_instr_i,
  input  logic                                    decoded_valid_i,
  output logic                                    decoded_ack_o,
  output scoreboard_entry                         issue_instr_o,
  output logic                                    issue_valid_o,
  input  logic                                    issue_ack_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_W-1:0]  wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]            wb_data_i,
  input  exception_t [NR_WB_PORTS-1:0]            wb_ex_i,
  input  logic [NR_WB_PORTS-1:0]                  wb_valid_i,
  input  logic [4:0]                              rs1_i,
  input  logic [4:0]                              rs2_i,
  output logic [63:0]                             rs1_o,
  output logic [63:0]                             rs2_o,
  output logic                                    rs1_valid_o,
  output logic                                    rs2_valid_o,
  output scoreboard_entry                         commit_instr_o,
  output logic                                    commit_valid_o,
  input  logic                                    commit_ack_i
);

  localparam int unsigned c_cnt_w = TRANS_ID_W + 1;
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(NR_ENTRIES);

  scoreboard_entry        r_mem [NR_ENTRIES];
  logic [NR_ENTRIES-1:0]  r_occupied;
  logic [NR_ENTRIES-1:0]  r_issued;
  logic [TRANS_ID_W-1:0]  r_commit_ptr;
  logic [TRANS_ID_W-1:0]  r_issue_ptr;
  logic [TRANS_ID_W-1:0]  r_tail_ptr;
  logic [c_cnt_w-1:0]     r_count;

  logic                   w_insert;
  logic                   w_issue;
  logic                   w_commit;
  scoreboard_entry        w_new_entry;

  assign full_o         = (r_count == c_full_cnt);
  assign decoded_ack_o  = decoded_valid_i & ~full_o & ~flush_i;
  assign issue_valid_o  = r_occupied[r_issue_ptr] & ~r_issued[r_issue_ptr];
  assign commit_valid_o = r_occupied[r_commit_ptr] & r_issued[r_commit_ptr]
                        & r_mem[r_commit_ptr].valid;

  // Empty slots read as zero so stale payloads never leak out after reset.
  assign issue_instr_o  = r_occupied[r_issue_ptr]  ? r_mem[r_issue_ptr]  : '0;
  assign commit_instr_o = r_occupied[r_commit_ptr] ? r_mem[r_commit_ptr] : '0;

  assign w_insert = decoded_ack_o;
  assign w_issue  = issue_ack_i & issue_valid_o;
  assign w_commit = commit_ack_i & commit_valid_o;

  always_comb begin
    w_new_entry          = decoded_instr_i;
    w_new_entry.trans_id = TRANS_ID_MAX_W'(r_tail_ptr);
    w_new_entry.valid    = (decoded_instr_i.fu == NONE) | decoded_instr_i.ex.valid;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_occupied   <= '0;
      r_issued     <= '0;
      r_commit_ptr <= '0;
      r_issue_ptr  <= '0;
      r_tail_ptr   <= '0;
      r_count      <= '0;
    end else begin
      if (w_insert) begin
        r_occupied[r_tail_ptr] <= 1'b1;
        r_issued[r_tail_ptr]   <= 1'b0;
        r_tail_ptr             <= r_tail_ptr + 1'b1;
      end
      if (w_issue) begin
        r_issued[r_issue_ptr] <= 1'b1;
        r_issue_ptr           <= r_issue_ptr + 1'b1;
      end
      if (w_commit) begin
        r_occupied[r_commit_ptr] <= 1'b0;
        r_commit_ptr             <= r_commit_ptr + 1'b1;
      end
      r_count <= r_count + c_cnt_w'(w_insert) - c_cnt_w'(w_commit);
    end
  end

  // Ports are walked high to low so the lowest-index port lands last and wins.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i) begin
      if (w_insert) begin
        r_mem[r_tail_ptr] <= w_new_entry;
      end
      for (int p = int'(NR_WB_PORTS) - 1; p >= 0; p--) begin
        if (wb_valid_i[p] && r_occupied[wb_trans_id_i[p]] && r_issued[wb_trans_id_i[p]]) begin
          r_mem[wb_trans_id_i[p]].result <= wb_data_i[p];
          r_mem[wb_trans_id_i[p]].ex     <= wb_ex_i[p];
          r_mem[wb_trans_id_i[p]].valid  <= 1'b1;
        end
      end
    end
  end

`ifdef SB_FORWARD_EN
  logic [TRANS_ID_W-1:0] w_fwd_idx;

  // Scan from head to tail; a later hit is younger and overrides earlier ones.
  always_comb begin
    rs1_o       = '0;
    rs2_o       = '0;
    rs1_valid_o = 1'b0;
    rs2_valid_o = 1'b0;
    w_fwd_idx   = '0;
    for (int k = 0; k < int'(NR_ENTRIES); k++) begin
      w_fwd_idx = r_commit_ptr + TRANS_ID_W'(k);
      if (r_occupied[w_fwd_idx] && r_mem[w_fwd_idx].valid) begin
        if (rs1_i != 5'd0 && r_mem[w_fwd_idx].rd == rs1_i) begin
          rs1_o       = r_mem[w_fwd_idx].result;
          rs1_valid_o = 1'b1;
        end
        if (rs2_i != 5'd0 && r_mem[w_fwd_idx].rd == rs2_i) begin
          rs2_o       = r_mem[w_fwd_idx].result;
          rs2_valid_o = 1'b1;
        end
      end
    end
  end
`else
  logic w_unused_rs;

  assign w_unused_rs = ^{rs1_i, rs2_i};
  assign rs1_o       = '0;
  assign rs2_o       = '0;
  assign rs1_valid_o = 1'b0;
  assign rs2_valid_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : tb_issue_scoreboard
// Brief   : Directed bench for issue_scoreboard with a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================

module tb_issue_scoreboard;
  import ariane_pkg::*;

  localparam int NR = 8;
  localparam int NP = 2;
  localparam int TW = 3;

  logic                     clk;
  logic                     rst_ni;
  logic                     flush_i;
  logic                     full_o;
  scoreboard_entry          decoded_instr_i;
  logic                     decoded_valid_i;
  logic                     decoded_ack_o;
  scoreboard_entry          issue_instr_o;
  logic                     issue_valid_o;
  logic                     issue_ack_i;
  logic [NP-1:0][TW-1:0]    wb_trans_id_i;
  logic [NP-1:0][63:0]      wb_data_i;
  exception_t [NP-1:0]      wb_ex_i;
  logic [NP-1:0]            wb_valid_i;
  logic [4:0]               rs1_i;
  logic [4:0]               rs2_i;
  logic [63:0]              rs1_o;
  logic [63:0]              rs2_o;
  logic                     rs1_valid_o;
  logic                     rs2_valid_o;
  scoreboard_entry          commit_instr_o;
  logic                     commit_valid_o;
  logic                     commit_ack_i;

  int n_tests = 0;
  int n_fail  = 0;

  issue_scoreboard #(.NR_ENTRIES(NR), .NR_WB_PORTS(NP)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .full_o(full_o),
    .decoded_instr_i(decoded_instr_i), .decoded_valid_i(decoded_valid_i),
    .decoded_ack_o(decoded_ack_o), .issue_instr_o(issue_instr_o),
    .issue_valid_o(issue_valid_o), .issue_ack_i(issue_ack_i),
    .wb_trans_id_i(wb_trans_id_i), .wb_data_i(wb_data_i), .wb_ex_i(wb_ex_i),
    .wb_valid_i(wb_valid_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_o(rs1_o),
    .rs2_o(rs2_o), .rs1_valid_o(rs1_valid_o), .rs2_valid_o(rs2_valid_o),
    .commit_instr_o(commit_instr_o), .commit_valid_o(commit_valid_o),
    .commit_ack_i(commit_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // In-flight instructions in program order; index 0 is the oldest.
  typedef struct packed {
    logic [TW-1:0] id;
    logic [4:0]    rd;
    logic          issued;
    logic          valid;
    logic [63:0]   result;
  } m_ent_t;

  m_ent_t        mq[$];
  logic [TW-1:0] m_tail = '0;

  always @(negedge clk) begin : cmp
    int            iss_idx;
    bit            e_full, e_ack, e_iv, e_cv, e_r1v, e_r2v;
    logic [63:0]   e_r1, e_r2;
    bit            seen [NR];
    m_ent_t        t;

    e_full  = (mq.size() == NR);
    e_ack   = decoded_valid_i && !e_full && !flush_i;
    iss_idx = -1;
    for (int i = 0; i < mq.size(); i++)
      if (iss_idx < 0 && !mq[i].issued) iss_idx = i;
    e_iv  = (iss_idx >= 0);
    e_cv  = (mq.size() > 0) && mq[0].issued && mq[0].valid;
    e_r1v = 1'b0; e_r1 = '0; e_r2v = 1'b0; e_r2 = '0;
`ifdef SB_FORWARD_EN
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!e_r1v && mq[i].valid && rs1_i != 0 && mq[i].rd == rs1_i) begin
        e_r1v = 1'b1; e_r1 = mq[i].result;
      end
      if (!e_r2v && mq[i].valid && rs2_i != 0 && mq[i].rd == rs2_i) begin
        e_r2v = 1'b1; e_r2 = mq[i].result;
      end
    end
`endif
    chk("full", full_o, e_full);
    chk("decoded_ack", decoded_ack_o, e_ack);
    chk("issue_valid", issue_valid_o, e_iv);
    chk("commit_valid", commit_valid_o, e_cv);
    chk("rs1_valid", rs1_valid_o, e_r1v);
    chk("rs2_valid", rs2_valid_o, e_r2v);
    chk("rs1_data", rs1_o, e_r1);
    chk("rs2_data", rs2_o, e_r2);
    if (e_iv) begin
      chk("issue_id", issue_instr_o.trans_id, mq[iss_idx].id);
      chk("issue_rd", issue_instr_o.rd, mq[iss_idx].rd);
    end
    if (e_cv) begin
      chk("commit_id", commit_instr_o.trans_id, mq[0].id);
      chk("commit_result", commit_instr_o.result, mq[0].result);
    end

    // Advance the model to the state after the coming rising edge.
    if (!rst_ni || flush_i) begin
      mq.delete();
      m_tail = '0;
    end else begin
      for (int i = 0; i < NR; i++) seen[i] = 1'b0;
      for (int p = 0; p < NP; p++) begin
        if (wb_valid_i[p] && !seen[wb_trans_id_i[p]]) begin
          seen[wb_trans_id_i[p]] = 1'b1;
          for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].id == wb_trans_id_i[p] && mq[i].issued) begin
              t = mq[i]; t.valid = 1'b1; t.result = wb_data_i[p]; mq[i] = t;
            end
          end
        end
      end
      if (issue_ack_i && e_iv) begin
        t = mq[iss_idx]; t.issued = 1'b1; mq[iss_idx] = t;
      end
      if (commit_ack_i && e_cv) void'(mq.pop_front());
      if (e_ack) begin
        t.id     = m_tail;
        t.rd     = decoded_instr_i.rd;
        t.issued = 1'b0;
        t.valid  = (decoded_instr_i.fu == NONE) || decoded_instr_i.ex.valid;
        t.result = decoded_instr_i.result;
        mq.push_back(t);
        m_tail = m_tail + 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle();
    flush_i = 1'b0; decoded_instr_i = '0; decoded_valid_i = 1'b0;
    issue_ack_i = 1'b0; commit_ack_i = 1'b0; wb_trans_id_i = '0;
    wb_data_i = '0; wb_ex_i = '0; wb_valid_i = '0; rs1_i = '0; rs2_i = '0;
  endtask

  task automatic ins(input logic [4:0] rd, input fu_t fu, input logic [63:0] res, input logic exv);
    decoded_instr_i          = '0;
    decoded_instr_i.pc       = 64'h8000_0000 + res;
    decoded_instr_i.rd       = rd;
    decoded_instr_i.fu       = fu;
    decoded_instr_i.result   = res;
    decoded_instr_i.ex.valid = exv;
    decoded_valid_i          = 1'b1;
  endtask

  task automatic set_wb(input int port, input logic [TW-1:0] id, input logic [63:0] data);
    wb_valid_i[port]    = 1'b1;
    wb_trans_id_i[port] = id;
    wb_data_i[port]     = data;
  endtask

  task automatic clr_wb();
    wb_valid_i = '0; wb_trans_id_i = '0; wb_data_i = '0;
  endtask

  logic [63:0] exp_c [4];
  logic [63:0] exp_d [4];

  initial begin
    exp_c[0] = 64'h100; exp_c[1] = 64'h101; exp_c[2] = 64'h102; exp_c[3] = 64'hDEAD;
    exp_d[0] = 64'h11;  exp_d[1] = 64'h55;  exp_d[2] = 64'h66;  exp_d[3] = 64'h77;
    idle();
    rst_ni = 1'b0;
    decoded_valid_i = 1'b1;
    at_neg();
    chk("rst_ack_follows_valid", decoded_ack_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_issue_valid", issue_valid_o, 0);
    chk("rst_commit_valid", commit_valid_o, 0);
    chk("rst_commit_instr", commit_instr_o.result, 0);
    tick(); tick();
    rst_ni = 1'b1;
    idle();

    // Fill all eight slots, then offer a ninth.
    for (int i = 0; i < 8; i++) begin
      ins(5'(i + 1), ALU, 64'h0, 1'b0);
      tick();
    end
    at_neg();
    chk("full_after_8", full_o, 1);
    chk("ninth_ack", decoded_ack_o, 0);
    tick();
    decoded_valid_i = 1'b0;

    issue_ack_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("issue_seq_id", issue_instr_o.trans_id, 64'(k));
      tick();
    end
    issue_ack_i = 1'b0;
    set_wb(1, 3'd3, 64'hDEAD);
    set_wb(0, 3'd5, 64'hBAD);
    tick();
    clr_wb();
    at_neg();
    chk("head_not_done", commit_valid_o, 0);
    tick();
    set_wb(0, 3'd0, 64'h100);
    set_wb(1, 3'd1, 64'h101);
    tick();
    clr_wb();
    set_wb(0, 3'd2, 64'h102);
    tick();
    clr_wb();

    commit_ack_i = 1'b1;
    ins(5'd20, ALU, 64'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      at_neg();
      if (k == 0) chk("full_blocks_with_commit", decoded_ack_o, 0);
      chk("inorder_commit_id", commit_instr_o.trans_id, 64'(k));
      chk("inorder_commit_result", commit_instr_o.result, exp_c[k]);
      tick();
      decoded_valid_i = 1'b0;
    end
    commit_ack_i = 1'b0;

    issue_ack_i = 1'b1;
    for (int k = 4; k < 8; k++) begin
      at_neg();
      chk("issue_seq_id", issue_instr_o.trans_id, 64'(k));
      tick();
    end
    issue_ack_i = 1'b0;
    set_wb(0, 3'd4, 64'h11);
    set_wb(1, 3'd4, 64'h22);
    tick();
    clr_wb();
    set_wb(0, 3'd5, 64'h55);
    set_wb(1, 3'd6, 64'h66);
    tick();
    clr_wb();
    set_wb(0, 3'd7, 64'h77);
    tick();
    clr_wb();
    commit_ack_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("port_prio_commit_result", commit_instr_o.result, exp_d[k]);
      tick();
    end
    commit_ack_i = 1'b0;
    at_neg();
    chk("drained_full", full_o, 0);
    chk("drained_commit_valid", commit_valid_o, 0);
    tick();

    // Writebacks to an empty slot and to an unissued slot must both be dropped.
    set_wb(0, 3'd0, 64'h99);
    tick();
    clr_wb();
    ins(5'd9, ALU, 64'h0, 1'b0);
    tick();
    decoded_valid_i = 1'b0;
    set_wb(0, 3'd0, 64'h98);
    tick();
    clr_wb();
    issue_ack_i = 1'b1;
    tick();
    issue_ack_i = 1'b0;
    at_neg();
    chk("ignored_wb_not_valid", commit_valid_o, 0);
    tick();
    set_wb(0, 3'd0, 64'h42);
    tick();
    clr_wb();
    at_neg();
    chk("late_wb_valid", commit_valid_o, 1);
    chk("late_wb_result", commit_instr_o.result, 64'h42);
    tick();
    commit_ack_i = 1'b1;
    tick();
    commit_ack_i = 1'b0;

    // Streaming wrap-around: insert, issue and commit every cycle.
    issue_ack_i  = 1'b1;
    commit_ack_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ins(5'(i % 4 + 1), NONE, 64'h1000 + 64'(i), 1'b0);
      at_neg();
      if (i == 8) begin
        chk("wrap_issue_id", issue_instr_o.trans_id, 0);
        chk("wrap_issue_result", issue_instr_o.result, 64'h1007);
      end
      tick();
    end
    decoded_valid_i = 1'b0;
    repeat (3) tick();
    issue_ack_i  = 1'b0;
    commit_ack_i = 1'b0;
    at_neg();
    chk("wrap_drained_issue_valid", issue_valid_o, 0);
    chk("wrap_drained_commit_valid", commit_valid_o, 0);
    tick();

    ins(5'd5, NONE, 64'hA, 1'b0);
    tick();
    ins(5'd5, NONE, 64'hB, 1'b0);
    tick();
    ins(5'd6, ALU, 64'hC, 1'b1);
    tick();
    decoded_valid_i = 1'b0;
    rs1_i = 5'd5;
    rs2_i = 5'd6;
    at_neg();
`ifdef SB_FORWARD_EN
    chk("fwd_youngest_data", rs1_o, 64'hB);
    chk("fwd_youngest_hit", rs1_valid_o, 1);
    chk("fwd_exc_entry_data", rs2_o, 64'hC);
`else
    chk("fwd_disabled_hit", rs1_valid_o, 0);
    chk("fwd_disabled_data", rs1_o, 0);
`endif
    tick();
    flush_i = 1'b1;
    ins(5'd7, NONE, 64'hD, 1'b0);
    at_neg();
    chk("flush_blocks_ack", decoded_ack_o, 0);
    tick();
    flush_i = 1'b0;
    decoded_valid_i = 1'b0;
    at_neg();
    chk("flush_full", full_o, 0);
    chk("flush_issue_valid", issue_valid_o, 0);
    chk("flush_commit_valid", commit_valid_o, 0);
    chk("flush_rs1_valid", rs1_valid_o, 0);
    tick();

    ins(5'd3, ALU, 64'h0, 1'b0);
    tick();
    tick();
    decoded_valid_i = 1'b0;
    issue_ack_i = 1'b1;
    tick();
    issue_ack_i = 1'b0;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    at_neg();
    chk("midrun_rst_issue_valid", issue_valid_o, 0);
    chk("midrun_rst_full", full_o, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
